// File: rtl/score_tracker.sv
// score_tracker: score bookkeeping for the two-player stacker.
//
// Counts successful placements per player, sequences turn A then turn B, keeps
// the session high score and decides when the score display shows the high
// score instead of the player scores. All outputs are registered.
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            synchronous active-low reset
//   start          pulse, starts a new game (from IDLE or OVER only)
//   place_ok       pulse, active player landed a block
//   place_miss     pulse, active player missed; ends the turn
//   hs_btn         level, request high-score view (IDLE/OVER only)
//   pA_score       player A score
//   pB_score       player B score
//   highscore      best single-player score since reset
//   highscore_disp 1 = display shows the high score
//   turn_b         1 while player B is active
//   game_over      1 in OVER
//
// Optional feature (macro HS_AUTO_SHOW_EN): the high score is shown for
// HS_SHOW_CYCLES cycles after every game over.
module score_tracker #(
    parameter int unsigned MAX_SCORE      = 15,
    parameter int unsigned HS_SHOW_CYCLES = 200000000,
    parameter int unsigned TMR_W          = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       place_ok,
    input  logic       place_miss,
    input  logic       hs_btn,
    output logic [3:0] pA_score,
    output logic [3:0] pB_score,
    output logic [3:0] highscore,
    output logic       highscore_disp,
    output logic       turn_b,
    output logic       game_over
);

    localparam logic [3:0] MaxScore = 4'(MAX_SCORE);

    typedef enum logic [1:0] {StIdle, StTurnA, StTurnB, StOver} state_e;

    state_e     state_q, state_d;
    logic [3:0] pa_q, pa_d;
    logic [3:0] pb_q, pb_d;
    logic [3:0] hs_q, hs_d;
    logic       disp_q, disp_d;
    logic       disp_base;
    logic       enter_over;

    always_comb begin
        state_d    = state_q;
        pa_d       = pa_q;
        pb_d       = pb_q;
        hs_d       = hs_q;
        disp_base  = 1'b0;
        enter_over = 1'b0;

        unique case (state_q)
            StIdle, StOver: begin
                disp_base = hs_btn;
                if (start) begin
                    state_d   = StTurnA;
                    pa_d      = '0;
                    pb_d      = '0;
                    disp_base = 1'b0;
                end
            end
            StTurnA: begin
                // A miss beats a simultaneous place_ok: no increment.
                if (place_miss) begin
                    state_d = StTurnB;
                end else if (place_ok && pa_q != MaxScore) begin
                    pa_d = pa_q + 4'd1;
                    if (pa_d == MaxScore) state_d = StTurnB;
                end
            end
            StTurnB: begin
                if (place_miss) begin
                    state_d = StOver;
                end else if (place_ok && pb_q != MaxScore) begin
                    pb_d = pb_q + 4'd1;
                    if (pb_d == MaxScore) state_d = StOver;
                end
                enter_over = (state_d == StOver);
            end
            default: state_d = StIdle;
        endcase

        // B's final increment is taken from pb_d so it counts on the entry edge.
        if (enter_over) begin
            if (pa_q > hs_d) hs_d = pa_q;
            if (pb_d > hs_d) hs_d = pb_d;
        end
    end

`ifdef HS_AUTO_SHOW_EN
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Entry loads N-1; display stays forced while the timer is non-zero, which
    // gives exactly N cycles including the entry cycle.
    always_comb begin
        tmr_d  = '0;
        disp_d = disp_base;
        if (enter_over) begin
            tmr_d  = TMR_W'(HS_SHOW_CYCLES - 1);
            disp_d = 1'b1;
        end else if (state_q == StOver && !start && tmr_q != '0) begin
            tmr_d  = tmr_q - 1'b1;
            disp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) tmr_q <= '0;
        else      tmr_q <= tmr_d;
    end
`else
    logic [TMR_W-1:0] unused_tmr_cfg;
    assign unused_tmr_cfg = TMR_W'(HS_SHOW_CYCLES);
    assign disp_d         = disp_base;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            pa_q    <= '0;
            pb_q    <= '0;
            hs_q    <= '0;
            disp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            hs_q    <= hs_d;
            disp_q  <= disp_d;
        end
    end

    assign pA_score       = pa_q;
    assign pB_score       = pb_q;
    assign highscore      = hs_q;
    assign highscore_disp = disp_q;
    assign turn_b         = (state_q == StTurnB);
    assign game_over      = (state_q == StOver);

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker. A second instance with MAX_SCORE=4 shares
// the stimulus and is checked only in the saturation section.
module tb_score_tracker;

`ifdef HS_AUTO_SHOW_EN
    localparam logic AutoShow = 1'b1;
`else
    localparam logic AutoShow = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       place_ok = 1'b0;
    logic       place_miss = 1'b0;
    logic       hs_btn = 1'b0;
    logic [3:0] pa, pb, hs;
    logic       disp, turn_b, game_over;
    logic [3:0] pa4, pb4, hs4;
    logic       disp4, turn_b4, game_over4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    score_tracker #(.MAX_SCORE(15), .HS_SHOW_CYCLES(10), .TMR_W(28)) dut (
        .clk(clk), .rst(rst), .start(start), .place_ok(place_ok),
        .place_miss(place_miss), .hs_btn(hs_btn), .pA_score(pa), .pB_score(pb),
        .highscore(hs), .highscore_disp(disp), .turn_b(turn_b), .game_over(game_over)
    );

    score_tracker #(.MAX_SCORE(4), .HS_SHOW_CYCLES(10), .TMR_W(28)) dut4 (
        .clk(clk), .rst(rst), .start(start), .place_ok(place_ok),
        .place_miss(place_miss), .hs_btn(hs_btn), .pA_score(pa4), .pB_score(pb4),
        .highscore(hs4), .highscore_disp(disp4), .turn_b(turn_b4),
        .game_over(game_over4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock with the given pulses; outputs sampled 1 time unit after the edge.
    task automatic step(input logic s, input logic ok, input logic miss);
        @(negedge clk);
        start = s; place_ok = ok; place_miss = miss;
        @(posedge clk);
        #1;
        start = 1'b0; place_ok = 1'b0; place_miss = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pa"}, 32'(pa), 0);
        chk({tag, "_pb"}, 32'(pb), 0);
        chk({tag, "_hs"}, 32'(hs), 0);
        chk({tag, "_disp"}, 32'(disp), 0);
        chk({tag, "_turn_b"}, 32'(turn_b), 0);
        chk({tag, "_game_over"}, 32'(game_over), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_pa4", 32'(pa4), 0);
        @(negedge clk) rst = 1'b1;

        // Basic game: A=3, B=5
        step(1, 0, 0);
        chk("basic_start_pa", 32'(pa), 0);
        chk("basic_start_turn_b", 32'(turn_b), 0);
        chk("basic_start_go", 32'(game_over), 0);
        repeat (3) step(0, 1, 0);
        chk("basic_pa3", 32'(pa), 3);
        chk("basic_turn_a", 32'(turn_b), 0);
        step(0, 0, 1);
        chk("basic_turn_b", 32'(turn_b), 1);
        chk("basic_pa_hold", 32'(pa), 3);
        repeat (5) step(0, 1, 0);
        chk("basic_pb5", 32'(pb), 5);
        step(0, 0, 1);
        chk("basic_go", 32'(game_over), 1);
        chk("basic_turn_b_off", 32'(turn_b), 0);
        chk("basic_hs5", 32'(hs), 5);
        chk("basic_final_pa", 32'(pa), 3);
        chk("basic_final_pb", 32'(pb), 5);
        chk("basic_disp_entry", 32'(disp), 32'(AutoShow));
`ifdef HS_AUTO_SHOW_EN
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0);
            chk("auto_disp_on", 32'(disp), 1);
        end
        step(0, 0, 0);
        chk("auto_disp_expired", 32'(disp), 0);
`else
        step(0, 0, 0);
        chk("over_disp_btn0", 32'(disp), 0);
`endif
        step(0, 1, 0);
        chk("over_ok_ignored_pa", 32'(pa), 3);
        chk("over_ok_ignored_pb", 32'(pb), 5);

        // Priority and ignored inputs
        step(1, 0, 0);
        chk("restart_pa", 32'(pa), 0);
        chk("restart_pb", 32'(pb), 0);
        chk("restart_go", 32'(game_over), 0);
        chk("restart_disp", 32'(disp), 0);
        step(0, 1, 0);
        chk("prio_pa1", 32'(pa), 1);
        step(0, 1, 1);
        chk("prio_miss_wins_pa", 32'(pa), 1);
        chk("prio_to_b", 32'(turn_b), 1);
        step(1, 0, 0);
        chk("start_in_b_turn", 32'(turn_b), 1);
        chk("start_in_b_go", 32'(game_over), 0);
        chk("start_in_b_pa", 32'(pa), 1);
        chk("start_in_b_pb", 32'(pb), 0);
        step(0, 0, 1);
        chk("prio_go", 32'(game_over), 1);
        chk("prio_hs_kept", 32'(hs), 5);

        // Game reaching high score 6; start mid auto-show
        step(1, 0, 0);
        repeat (6) step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("g6_hs", 32'(hs), 6);
        repeat (4) step(0, 0, 0);
`ifdef HS_AUTO_SHOW_EN
        chk("auto_cycle5_disp", 32'(disp), 1);
`endif
        step(1, 0, 0);
        chk("start_clears_disp", 32'(disp), 0);
        chk("start_turn_a", 32'(turn_b), 0);

        // Reset mid-game in TURN_B with pB=2, highscore=6
        step(0, 0, 1);
        repeat (2) step(0, 1, 0);
        chk("pre_rst_pb", 32'(pb), 2);
        chk("pre_rst_hs", 32'(hs), 6);
        chk("pre_rst_turn_b", 32'(turn_b), 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("rst_edge");
        @(negedge clk);
        rst = 1'b1;
        place_ok = 1'b1;
        @(posedge clk);
        #1;
        place_ok = 1'b0;
        chk_all_zero("rst_after");

        // High-score retention: 7/2 then 3/7
        step(1, 0, 0);
        repeat (7) step(0, 1, 0);
        chk("hs_g1_pa7", 32'(pa), 7);
        step(0, 0, 1);
        repeat (2) step(0, 1, 0);
        step(0, 0, 1);
        chk("hs_g1_hs7", 32'(hs), 7);
        step(1, 0, 0);
        chk("hs_g2_clear_pa", 32'(pa), 0);
        chk("hs_g2_clear_pb", 32'(pb), 0);
        chk("hs_g2_hs_kept", 32'(hs), 7);
        hs_btn = 1'b1;
        repeat (3) step(0, 1, 0);
        chk("hs_g2_pa3", 32'(pa), 3);
        chk("turn_a_disp_forced0", 32'(disp), 0);
        step(0, 0, 1);
        repeat (7) step(0, 1, 0);
        chk("hs_g2_pb7", 32'(pb), 7);
        chk("turn_b_disp_forced0", 32'(disp), 0);
        step(0, 0, 1);
        chk("hs_g2_go", 32'(game_over), 1);
        chk("hs_tie_kept", 32'(hs), 7);
        chk("hs_g2_disp_entry", 32'(disp), 32'(AutoShow));
        step(0, 0, 0);
        chk("hs_btn_disp", 32'(disp), 1);
        hs_btn = 1'b0;
        step(0, 0, 0);
        chk("hs_btn_release", 32'(disp), 32'(AutoShow));

        // Saturation on the MAX_SCORE=4 instance
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk) rst = 1'b1;
        step(1, 0, 0);
        repeat (3) step(0, 1, 0);
        chk("sat_pa3", 32'(pa4), 3);
        chk("sat_still_a", 32'(turn_b4), 0);
        step(0, 1, 0);
        chk("sat_pa4", 32'(pa4), 4);
        chk("sat_to_b", 32'(turn_b4), 1);
        step(0, 1, 0);
        chk("sat_pb1", 32'(pb4), 1);
        chk("sat_pa_stays", 32'(pa4), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Game-level score bookkeeping for the two-player stacker.
- Counts successful placements per player and sequences turns A then B.
- Keeps a session high score and decides when the seven-segment display stage shows the high score instead of the player scores.
- Outputs feed the score display stage directly: 4-bit scores, 4-bit high score, display select.

Parameters:
- MAX_SCORE, 15, saturation ceiling for each player score (1..15); reaching it ends that player's turn.
- HS_SHOW_CYCLES, 200000000, clk cycles the high score is auto-shown after game over (used only with HS_AUTO_SHOW_EN).
- TMR_W, 28, width of the auto-show timer; must hold HS_SHOW_CYCLES.

Ports:
- clk  input  1  system clock; all logic is posedge clk.
- rst  input  1  reset, synchronous, active-low: state clears on a rising clk edge while rst=0.
- start  input  1  one-cycle pulse; starts a new game.
- place_ok  input  1  one-cycle pulse; active player landed a block.
- place_miss  input  1  one-cycle pulse; active player missed, turn ends.
- hs_btn  input  1  level, already debounced; request high-score view.
- pA_score  output  4  player A score.
- pB_score  output  4  player B score.
- highscore  output  4  best single-player score since reset.
- highscore_disp  output  1  1 = display shows the high score.
- turn_b  output  1  1 while player B is active.
- game_over  output  1  1 in state OVER.

Behaviour:
- All outputs are registered, with one clk of latency from the input event.
- Reset values: pA_score=0, pB_score=0, highscore=0, highscore_disp=0, turn_b=0, game_over=0, state=IDLE, timer=0.
- Reset mid-game aborts immediately; the high score is also cleared.
- State machine:
  - IDLE: start -> clear both scores, go to TURN_A.
  - TURN_A: place_ok -> pA_score+1. If the new value equals MAX_SCORE, go to TURN_B. place_miss -> go to TURN_B.
  - TURN_B: same rules on pB_score; exit goes to OVER. turn_b=1 only in TURN_B.
  - OVER: game_over=1. start -> clear both scores, go to TURN_A. highscore is kept.
- Input priority and ignored events:
  - place_ok and place_miss in the same cycle: miss wins, no increment.
  - start is ignored in TURN_A and TURN_B.
  - place_* pulses are ignored in IDLE and OVER.
- Saturation: a score never exceeds MAX_SCORE. No wrap-around.
- High score update:
  - On the cycle OVER is entered: highscore <= max(highscore, pA_score, pB_score, including any increment in the transition cycle).
  - Ties leave highscore unchanged.
- highscore_disp, base behaviour:
  - In IDLE or OVER: highscore_disp follows hs_btn with one cycle of delay.
  - In TURN_A and TURN_B it is forced to 0, regardless of hs_btn.
  - start in IDLE or OVER clears highscore_disp on the same edge it enters TURN_A.

Optional Feature:
- Macro: HS_AUTO_SHOW_EN.
- Defined:
  - On entry to OVER, the timer loads HS_SHOW_CYCLES-1 and highscore_disp=1 for exactly HS_SHOW_CYCLES cycles.
  - After that, highscore_disp returns to following hs_btn.
  - hs_btn held during the timer keeps highscore_disp=1 after expiry.
  - start or reset during the timer clears the timer and highscore_disp.
- Not defined:
  - No timer logic; highscore_disp follows only the base rules.
  - HS_SHOW_CYCLES and TMR_W are unused.

Test Plan:
- Basic game:
  - Stimulus: reset; start; 3 place_ok; place_miss; 5 place_ok; place_miss.
  - Required: pA_score=3, pB_score=5, game_over=1, highscore=5 one cycle after OVER entry, turn_b back to 0.
- Saturation (MAX_SCORE=4):
  - Stimulus: start; 4 place_ok in A's turn.
  - Required: pA_score=4, turn_b=1 next cycle. A 5th place_ok counts for B (pB_score=1); pA_score stays 4.
- Priority and ignored inputs:
  - Stimulus: place_ok and place_miss in the same cycle during TURN_A; start during TURN_B.
  - Required: pA_score unchanged and turn moves to B; start has no effect.
- High-score retention:
  - Stimulus: game 1 scores 7/2; start; game 2 scores 3/7; then hs_btn=1 in OVER.
  - Required: highscore=7 after both games (tie kept); scores cleared on the second start; highscore_disp=1 one cycle after hs_btn; highscore_disp=0 during turns even with hs_btn=1.
- Reset mid-game:
  - Stimulus: rst=0 for one edge during TURN_B with pB_score=2 and highscore=6.
  - Required: all outputs are 0 and state is IDLE. Check both at the edge where rst=0 and one edge later.
- HS_AUTO_SHOW_EN (HS_SHOW_CYCLES=10):
  - Required: highscore_disp=1 for exactly 10 cycles after OVER entry, then 0 with hs_btn=0.
  - Stimulus: start at cycle 5 of the timer.
  - Required: highscore_disp=0 immediately after that start.
